// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory responder with fixed wait states
module dmem_responder #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        DoneM,
   output logic        AddrErrM
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic [31:0]   mem_q [DEPTH];

   logic          accept;
   logic          finish;
   logic          legal;
   logic [IW-1:0] idx;

   assign accept = (state_q == IDLE) && MemReqM;
   // finish is true only on the edge that moves BUSY into RESP
   assign finish = (state_q == BUSY) && (cnt_q == 4'd1);
   assign legal  = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < 32'(DEPTH));
   assign idx    = addr_q[IW+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (MemReqM) begin
               state_d = BUSY;
               cnt_d   = 4'(WAIT);
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= MemWriteM;
            addr_q  <= AddrM;
            wdata_q <= WriteDataM;
         end
         if (finish && !we_q) begin
            rdata_q <= legal ? mem_q[idx] : 32'd0;
         end
      end
   end

   // Array has no reset; an abandoned access never reaches finish
   always_ff @(posedge clk) begin
      if (finish && we_q && legal) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign ReadDataM = rdata_q;
   assign StallM    = accept || (state_q == BUSY);
   assign DoneM     = (state_q == RESP);
   assign AddrErrM  = (state_q == RESP) && !legal;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemReqM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [31:0] AddrM = 32'd0;
   logic [31:0] WriteDataM = 32'd0;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        DoneM;
   logic        AddrErrM;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs [10];

   dmem_responder #(.DEPTH(64), .WAIT(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReqM    (MemReqM),
      .MemWriteM  (MemWriteM),
      .AddrM      (AddrM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .DoneM      (DoneM),
      .AddrErrM   (AddrErrM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Full access accepted at T; inputs are scrambled while BUSY to prove they are ignored
   task automatic access(input string tag, input vec_t v);
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = v.we; AddrM = v.addr; WriteDataM = v.wd;
      #1;
      chk({tag, "_stall_T"}, StallM, 1);
      chk({tag, "_done_T"}, DoneM, 0);
      @(negedge clk);
      MemReqM = 1'b0; MemWriteM = ~v.we; AddrM = v.addr ^ 32'h4; WriteDataM = ~v.wd;
      #1;
      chk({tag, "_stall_T1"}, StallM, 1);
      chk({tag, "_done_T1"}, DoneM, 0);
      chk({tag, "_err_T1"}, AddrErrM, 0);
      @(negedge clk);
      MemReqM = 1'b1;
      #1;
      chk({tag, "_stall_T2"}, StallM, 1);
      chk({tag, "_done_T2"}, DoneM, 0);
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      chk({tag, "_stall_T3"}, StallM, 0);
      chk({tag, "_done_T3"}, DoneM, 1);
      chk({tag, "_err_T3"}, AddrErrM, v.err);
      chk({tag, "_rdata_T3"}, ReadDataM, v.rd);
      @(negedge clk);
      #1;
      chk({tag, "_done_T4"}, DoneM, 0);
      chk({tag, "_err_T4"}, AddrErrM, 0);
      chk({tag, "_stall_T4"}, StallM, 0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h00,  32'h11111111, 1'b0, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 32'hFC,  32'h22222222, 1'b0, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0};
      vecs[5] = '{1'b1, 32'h100, 32'h33333333, 1'b1, 32'h0};
      vecs[6] = '{1'b1, 32'h02,  32'h44444444, 1'b1, 32'h0};
      vecs[7] = '{1'b0, 32'hFC,  32'h0,        1'b0, 32'h22222222};
      vecs[8] = '{1'b0, 32'h00,  32'h0,        1'b0, 32'h11111111};
      vecs[9] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};

      // Reset state; StallM follows MemReqM even while in reset
      #1;
      chk("rst_stall_lo", StallM, 0);
      chk("rst_done", DoneM, 0);
      chk("rst_err", AddrErrM, 0);
      chk("rst_rdata", ReadDataM, 0);
      MemReqM = 1'b1;
      #1;
      chk("rst_stall_hi", StallM, 1);
      @(negedge clk);
      MemReqM = 1'b0;
      reset = 1'b0;
      #1;
      chk("rel_done", DoneM, 0);
      chk("rel_stall", StallM, 0);

      for (int i = 0; i < 10; i++) begin
         access($sformatf("v%0d", i), vecs[i]);
      end

      // Load presented during RESP of a store is accepted in the following IDLE cycle
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = 1'b1; AddrM = 32'h20; WriteDataM = 32'h5;
      #1;
      chk("A_stall_T", StallM, 1);
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      chk("A_stall_T1", StallM, 1);
      @(negedge clk);
      #1;
      chk("A_stall_T2", StallM, 1);
      chk("A_done_T2", DoneM, 0);
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = 1'b0; AddrM = 32'h20; WriteDataM = 32'h0;
      #1;
      chk("A_resp_stall", StallM, 0);
      chk("A_resp_done", DoneM, 1);
      chk("A_resp_err", AddrErrM, 0);
      chk("A_resp_rdata", ReadDataM, 32'hDEADBEEF);
      @(negedge clk);
      #1;
      chk("A_acc_stall", StallM, 1);
      chk("A_acc_done", DoneM, 0);
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      chk("A_ld_stall1", StallM, 1);
      chk("A_ld_done1", DoneM, 0);
      @(negedge clk);
      #1;
      chk("A_ld_stall2", StallM, 1);
      chk("A_ld_done2", DoneM, 0);
      @(negedge clk);
      #1;
      chk("A_ld_done3", DoneM, 1);
      chk("A_ld_stall3", StallM, 0);
      chk("A_ld_rdata", ReadDataM, 32'h5);
      chk("A_ld_err", AddrErrM, 0);

      // Reset during BUSY abandons the store
      access("B_pre", '{1'b1, 32'h20, 32'h1, 1'b0, 32'h5});
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = 1'b1; AddrM = 32'h20; WriteDataM = 32'h12345678;
      #1;
      chk("B_stall_T", StallM, 1);
      @(negedge clk);
      MemReqM = 1'b0;
      reset = 1'b1;
      #1;
      chk("B_rst_stall", StallM, 0);
      chk("B_rst_done", DoneM, 0);
      chk("B_rst_rdata", ReadDataM, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("B_rel_done", DoneM, 0);
      chk("B_rel_stall", StallM, 0);
      @(negedge clk);
      #1;
      chk("B_idle_done", DoneM, 0);
      access("B_ld", '{1'b0, 32'h20, 32'h0, 1'b0, 32'h1});

      // Load 0x08 with address moved to 0x0C during BUSY returns word 0x08
      access("C_st08", '{1'b1, 32'h08, 32'hA5A5A5A5, 1'b0, 32'h1});
      access("C_st0C", '{1'b1, 32'h0C, 32'h5A5A5A5A, 1'b0, 32'h1});
      access("C_ld08", '{1'b0, 32'h08, 32'h0, 1'b0, 32'hA5A5A5A5});
      access("C_ld0C", '{1'b0, 32'h0C, 32'h0, 1'b0, 32'h5A5A5A5A});

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
